// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : decoder_pkg
// Description : Mode and sweep-state encodings plus the one-hot helper shared
//               by the scanning decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam logic [1:0] MODE_DIRECT    = 2'b00;
    localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
    localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
    localparam logic [1:0] MODE_SWEEP     = 2'b11;

    localparam logic [1:0] SWEEP_IDLE = 2'd0;
    localparam logic [1:0] SWEEP_RUN  = 2'd1;
    localparam logic [1:0] SWEEP_DONE = 2'd2;

    localparam int c_MAX_OUT = 256;

    // Callers size-cast the result down to their own output count.
    function automatic logic [c_MAX_OUT-1:0] onehot(input int idx, input int num_out);
        onehot = '0;
        for (int i = 0; i < c_MAX_OUT; i++) begin
            onehot[i] = (i == idx) && (idx < num_out);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_scan_n_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Programmable step-tick generator, period div+1 clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    // >= so that a live decrease of div below the count still terminates the period
    assign tick = (r_cnt >= div);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            if (clr || tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_n
// Description : Registered binary-to-one-hot decoder with direct, scan-up,
//               scan-down and one-shot sweep modes.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int NUM_OUT    = 8,
    parameter int DIV_W      = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_valid,
    input  logic [DIV_W-1:0]   tick_div,
    output logic [NUM_OUT-1:0] y,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [SEL_W-1:0]   c_IDX_MAX = SEL_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] c_POL     = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [1:0]         r_mode;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [SEL_W-1:0]   r_last;
    logic [SEL_W-1:0]   w_last_nxt;
    logic [NUM_OUT-1:0] r_dec;
    logic [NUM_OUT-1:0] w_dec_nxt;
    logic [NUM_OUT-1:0] r_y;
    logic               r_wrap;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               w_wrap_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_tick;
    logic               w_mode_chg;
    logic               w_sel_oor;
    logic               w_sweep_start;

    assign w_mode_chg = (mode != r_mode);
    assign w_sel_oor  = (int'(sel) >= NUM_OUT);

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (w_mode_chg | w_sweep_start),
        .div  (tick_div),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_last_nxt    = r_last;
        w_dec_nxt     = r_dec;
        w_busy_nxt    = r_busy;
        w_err_nxt     = r_err;
        w_wrap_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_sweep_start = 1'b0;

        if (!en) begin
            w_dec_nxt = r_dec;
        end else if (w_mode_chg) begin
            // A mode switch restarts from index 0 and abandons any sweep silently
            w_idx_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = SWEEP_IDLE;
            if (mode == MODE_SCAN_UP || mode == MODE_SCAN_DOWN) begin
                w_dec_nxt = NUM_OUT'(onehot(0, NUM_OUT));
            end else begin
                w_dec_nxt = '0;
            end
        end else begin
            case (r_mode)
                MODE_DIRECT: begin
                    if (sel_valid) begin
                        w_idx_nxt = sel;
                        w_dec_nxt = NUM_OUT'(onehot(int'(sel), NUM_OUT));
                        if (w_sel_oor) begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                MODE_SCAN_UP: begin
                    if (w_tick) begin
                        w_wrap_nxt = (r_idx == c_IDX_MAX);
                        w_idx_nxt  = w_wrap_nxt ? '0 : r_idx + 1'b1;
                    end
                    w_dec_nxt = NUM_OUT'(onehot(int'(w_idx_nxt), NUM_OUT));
                end
                MODE_SCAN_DOWN: begin
                    if (w_tick) begin
                        w_wrap_nxt = (r_idx == '0);
                        w_idx_nxt  = w_wrap_nxt ? c_IDX_MAX : r_idx - 1'b1;
                    end
                    w_dec_nxt = NUM_OUT'(onehot(int'(w_idx_nxt), NUM_OUT));
                end
                default: begin
                    case (r_state)
                        SWEEP_IDLE: begin
                            w_dec_nxt = '0;
                            if (sel_valid) begin
                                w_last_nxt    = w_sel_oor ? c_IDX_MAX : sel;
                                w_idx_nxt     = '0;
                                w_busy_nxt    = 1'b1;
                                w_state_nxt   = SWEEP_RUN;
                                w_sweep_start = 1'b1;
                                w_dec_nxt     = NUM_OUT'(onehot(0, NUM_OUT));
                            end
                        end
                        SWEEP_RUN: begin
                            if (w_tick) begin
                                if (r_idx == r_last) begin
                                    w_state_nxt = SWEEP_DONE;
                                    w_busy_nxt  = 1'b0;
                                    w_done_nxt  = 1'b1;
                                    w_dec_nxt   = '0;
                                end else begin
                                    w_idx_nxt = r_idx + 1'b1;
                                    w_dec_nxt = NUM_OUT'(onehot(int'(w_idx_nxt), NUM_OUT));
                                end
                            end
                        end
                        default: begin
                            w_state_nxt = SWEEP_IDLE;
                            w_dec_nxt   = '0;
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= MODE_DIRECT;
            r_state <= SWEEP_IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_dec   <= '0;
            r_y     <= c_POL;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (en) begin
                r_mode <= mode;
            end
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_dec   <= w_dec_nxt;
            // r_dec keeps the decoded pattern across en=0 so DIRECT can restore it
            r_y     <= en ? (w_dec_nxt ^ c_POL) : c_POL;
            r_wrap  <= w_wrap_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign y    = r_y;
    assign idx  = r_idx;
    assign wrap = r_wrap;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire
